// File: rtl/alu_pkg.sv
// Shared ALU constants, opcodes and the result-buffer entry layout.
// Imported by the result buffer, its interface and the bench.
package alu_pkg;

  localparam int SEL_W = 4;
  localparam int Y_W   = 8;
  localparam int ENT_W = SEL_W + Y_W + 2;

  localparam logic [SEL_W-1:0] OP_INC_A  = 4'b0000;
  localparam logic [SEL_W-1:0] OP_INC_B  = 4'b0001;
  localparam logic [SEL_W-1:0] OP_XFER_A = 4'b0010;
  localparam logic [SEL_W-1:0] OP_XFER_B = 4'b0011;
  localparam logic [SEL_W-1:0] OP_DEC_A  = 4'b0100;
  localparam logic [SEL_W-1:0] OP_MUL    = 4'b0101;
  localparam logic [SEL_W-1:0] OP_ADD    = 4'b0110;
  localparam logic [SEL_W-1:0] OP_NOT_A  = 4'b1000;
  localparam logic [SEL_W-1:0] OP_NOT_B  = 4'b1001;
  localparam logic [SEL_W-1:0] OP_AND    = 4'b1010;
  localparam logic [SEL_W-1:0] OP_OR     = 4'b1011;
  localparam logic [SEL_W-1:0] OP_XOR    = 4'b1100;
  localparam logic [SEL_W-1:0] OP_XNOR   = 4'b1101;
  localparam logic [SEL_W-1:0] OP_NAND   = 4'b1110;
  localparam logic [SEL_W-1:0] OP_NOR    = 4'b1111;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [Y_W-1:0]   y;
    logic             zero;
    logic             neg;
  } res_t;

  typedef struct packed {
    logic             v;
    logic [SEL_W-1:0] sel;
  } inflt_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// Issue/result handshake bundle for alu_result_buffer.
// ALU_RESULT_STATS_EN adds the stat_ops/stat_stall counters.
interface alu_result_buffer_if;
  import alu_pkg::*;

  logic             issue_valid;
  logic [SEL_W-1:0] issue_sel;
  logic             issue_ready;
  logic [Y_W-1:0]   alu_y;
  logic             out_valid;
  logic             out_ready;
  logic [Y_W-1:0]   out_y;
  logic [SEL_W-1:0] out_sel;
  logic             out_zero;
  logic             out_neg;
  logic             out_logic;
`ifdef ALU_RESULT_STATS_EN
  logic [15:0]      stat_ops;
  logic [15:0]      stat_stall;
`endif

  modport master (
`ifdef ALU_RESULT_STATS_EN
    input  stat_ops, stat_stall,
`endif
    output issue_valid, issue_sel, alu_y, out_ready,
    input  issue_ready, out_valid, out_y, out_sel,
    input  out_zero, out_neg, out_logic
  );

  modport slave (
`ifdef ALU_RESULT_STATS_EN
    output stat_ops, stat_stall,
`endif
    input  issue_valid, issue_sel, alu_y, out_ready,
    output issue_ready, out_valid, out_y, out_sel,
    output out_zero, out_neg, out_logic
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO; occupancy counter gives full/empty.
// Head data reads as zero while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Tracks ALU ops through its latency and queues flagged results.
// ALU_RESULT_STATS_EN adds saturating capture/stall counters.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int DEPTH   = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_result_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 4;

  inflt_t                 pipe [ALU_LAT];
  logic [CW-1:0]          nfl;
  logic [CW-1:0]          credit;
  logic [$clog2(DEPTH):0] occ;
  logic                   rdy;
  logic                   acc;
  logic                   cap;
  logic                   pop;
  logic                   empty;
  logic                   full;
  res_t                   wr_ent;
  res_t                   hd;

  always_comb begin
    nfl = '0;
    for (int i = 0; i < ALU_LAT; i++) begin
      nfl = nfl + CW'(pipe[i].v);
    end
  end

  // Queued plus in-flight results bound what may still arrive.
  assign credit = CW'(occ) + nfl;
  assign rdy    = (credit < CW'(DEPTH));
  assign acc    = bus.issue_valid & rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALU_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: acc, sel: bus.issue_sel};
      for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign cap         = pipe[ALU_LAT-1].v;
  assign wr_ent.sel  = pipe[ALU_LAT-1].sel;
  assign wr_ent.y    = bus.alu_y;
  assign wr_ent.zero = (bus.alu_y == '0);
  assign wr_ent.neg  = bus.alu_y[Y_W-1];

  sync_fifo_fwft #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (hd),
    .empty (empty),
    .full  (full),
    .count (occ)
  );

  assign pop             = ~empty & bus.out_ready;
  assign bus.issue_ready = rdy;
  assign bus.out_valid   = ~empty;
  assign bus.out_y       = hd.y;
  assign bus.out_sel     = hd.sel;
  assign bus.out_zero    = hd.zero;
  assign bus.out_neg     = hd.neg;
  assign bus.out_logic   = hd.sel[SEL_W-1];

`ifdef ALU_RESULT_STATS_EN
  logic [15:0] ops_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (cap && ops_q != 16'hFFFF) ops_q <= ops_q + 1'b1;
      if (bus.issue_valid && !rdy && stall_q != 16'hFFFF)
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stat_ops   = ops_q;
  assign bus.stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer with a delay-line ALU model.
// Stats checks run when ALU_RESULT_STATS_EN is defined.
module tb_alu_result_buffer;
  import alu_pkg::*;

  parameter int ALU_LAT = 1;
  parameter int DEPTH   = 4;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] y;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [7:0] alu_in;
  logic [7:0] ydl [ALU_LAT];

  alu_result_buffer_if bus ();

  alu_result_buffer #(
    .ALU_LAT (ALU_LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks;
  int   errors;
  int   m_occ;
  logic mv [ALU_LAT];
  exp_t sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: result for the op presented ALU_LAT edges earlier.
  always @(posedge clk) begin
    ydl[0] <= alu_in;
    for (int i = 1; i < ALU_LAT; i++) ydl[i] <= ydl[i-1];
  end
  assign bus.alu_y = ydl[ALU_LAT-1];

  task automatic clear_model();
    m_occ = 0;
    sb.delete();
    for (int i = 0; i < ALU_LAT; i++) mv[i] = 1'b0;
  endtask

  task automatic step(input logic v, input logic [3:0] s,
                      input logic [7:0] y, input logic r);
    logic acc;
    logic pop;
    logic exp_rdy;
    logic [14:0] got;
    logic [14:0] exp;
    int nfl;
    bus.issue_valid = v;
    bus.issue_sel   = s;
    alu_in          = y;
    bus.out_ready   = r;
    #1;
    nfl = 0;
    for (int i = 0; i < ALU_LAT; i++) nfl += int'(mv[i]);
    exp_rdy = ((m_occ + nfl) < DEPTH);
    checks++;
    if (bus.issue_ready !== exp_rdy) begin
      errors++;
      $display("FAIL issue_ready got %b exp %b t=%0t",
               bus.issue_ready, exp_rdy, $time);
    end
    checks++;
    if (bus.out_valid !== (m_occ > 0)) begin
      errors++;
      $display("FAIL out_valid got %b exp %b t=%0t",
               bus.out_valid, (m_occ > 0), $time);
    end
    got = {bus.out_sel, bus.out_y, bus.out_zero, bus.out_neg, bus.out_logic};
    if (m_occ > 0)
      exp = {sb[0].sel, sb[0].y, (sb[0].y == 8'h00), sb[0].y[7], sb[0].sel[3]};
    else
      exp = '0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL head got %h exp %h t=%0t", got, exp, $time);
    end
    acc = v && exp_rdy;
    pop = (m_occ > 0) && r;
    if (acc) sb.push_back('{sel: s, y: y});
    @(posedge clk);
    if (pop) begin
      void'(sb.pop_front());
      m_occ--;
    end
    if (mv[ALU_LAT-1]) m_occ++;
    for (int i = ALU_LAT - 1; i > 0; i--) mv[i] = mv[i-1];
    mv[0] = acc;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 8'h00, r);
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_sel   = '0;
    bus.out_ready   = 1'b0;
    alu_in          = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.issue_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0",
               bus.issue_ready, bus.out_valid);
    end
    checks++;
    if ({bus.out_y, bus.out_sel, bus.out_zero, bus.out_neg,
         bus.out_logic} !== 15'h0) begin
      errors++;
      $display("FAIL reset_out got y=%h sel=%h exp 0", bus.out_y, bus.out_sel);
    end
  endtask

  task automatic test_single();
    int lat;
    lat = 0;
    step(1'b1, OP_INC_A, 8'h04, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      if (bus.out_valid === 1'b1 && lat == 0) lat = i;
      step(1'b0, 4'h0, 8'h00, 1'b1);
    end
    checks++;
    if (lat != ALU_LAT + 1) begin
      errors++;
      $display("FAIL latency got %0d exp %0d", lat, ALU_LAT + 1);
    end
  endtask

  task automatic test_flags();
    step(1'b1, OP_MUL, 8'hFA, 1'b1);
    step(1'b1, OP_NOR, 8'hF8, 1'b1);
    step(1'b1, OP_ADD, 8'h00, 1'b1);
    idle(ALU_LAT + 3, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL flags_drain got %0d left exp 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    int nacc;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.issue_ready === 1'b1) nacc++;
      step(1'b1, 4'(i + 8), 8'(i * 17 + 3), 1'b0);
    end
    checks++;
    if (nacc != DEPTH) begin
      errors++;
      $display("FAIL bp_accepts got %0d exp %0d", nacc, DEPTH);
    end
    idle(ALU_LAT + 1, 1'b0);
    idle(DEPTH, 1'b1);
    checks++;
    if (bus.issue_ready !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got rdy=%b left=%0d exp rdy=1 left=0",
               bus.issue_ready, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, OP_INC_B, 8'h11, 1'b0);
    step(1'b1, OP_XFER_A, 8'h22, 1'b0);
    idle(ALU_LAT + 1, 1'b0);
    for (int i = 0; i < 2 * DEPTH + 2; i++)
      step(1'b1, 4'(i), 8'(i * 7 + 1), 1'b1);
    idle(ALU_LAT + DEPTH + 2, 1'b1);
    checks++;
    if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain got left=%0d vld=%b exp 0",
               sb.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 2), 8'(i + 40), 1'b0);
    idle(ALU_LAT, 1'b0);
    step(1'b1, OP_XOR, 8'h55, 1'b0);
    rst_n = 1'b0;
    bus.issue_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst got vld=%b rdy=%b exp vld=0 rdy=1",
               bus.out_valid, bus.issue_ready);
    end
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(ALU_LAT + 4, 1'b1);
  endtask

`ifdef ALU_RESULT_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i), 8'(i + 1), 1'b1);
    idle(ALU_LAT + 2, 1'b1);
    checks++;
    if (bus.stat_ops !== 16'd5 || bus.stat_stall !== 16'd0) begin
      errors++;
      $display("FAIL stats_ops got ops=%0d stall=%0d exp 5 0",
               bus.stat_ops, bus.stat_stall);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 4'(i), 8'(i + 9), 1'b0);
    checks++;
    if (bus.stat_stall !== 16'd2) begin
      errors++;
      $display("FAIL stats_stall got %0d exp 2", bus.stat_stall);
    end
    idle(DEPTH + ALU_LAT + 1, 1'b1);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < ALU_LAT; i++) ydl[i] = 8'h00;
    test_reset();
    test_single();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_RESULT_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
